// File: rtl/timer0_peripheral_pkg.sv
// timer0_peripheral_pkg
//   Shared memory-map and OPTION_REG definitions for the Timer0 peripheral:
//   register addresses, the bank-mirror mask, OPTION bit positions, reset
//   values and the address decoder used by the bus responder.
package timer0_peripheral_pkg;

    // Register-file addresses (bank 0/1 view; bit 8 mirrors into banks 2/3)
    localparam logic [8:0] ADDR_TMR0        = 9'h001;
    localparam logic [8:0] ADDR_OPTION      = 9'h081;
    localparam logic [8:0] BANK_MIRROR_MASK = 9'h0FF;

    // OPTION_REG bit indices
    localparam int unsigned OPT_T0CS = 5;
    localparam int unsigned OPT_T0SE = 4;
    localparam int unsigned OPT_PSA  = 3;

    localparam logic [7:0] OPTION_RST = 8'hFF;

    // Instruction cycles during which counting is held off after a TMR0 write
    localparam logic [1:0] INHIBIT_LOAD = 2'd2;

    typedef enum logic [1:0] {
        REG_NONE   = 2'd0,
        REG_TMR0   = 2'd1,
        REG_OPTION = 2'd2
    } reg_sel_e;

    // Bit 8 is ignored so 0x101/0x181 alias 0x001/0x081.
    function automatic reg_sel_e decode_reg(input logic [8:0] addr);
        logic [8:0] masked;
        masked = addr & BANK_MIRROR_MASK;
        if (masked == ADDR_TMR0) begin
            return REG_TMR0;
        end else if (masked == ADDR_OPTION) begin
            return REG_OPTION;
        end else begin
            return REG_NONE;
        end
    endfunction

endpackage

// File: rtl/timer0_peripheral_t0cki_edge_sync.sv
// t0cki_edge_sync
//   Synchronizes the asynchronous T0CKI pin through SYNC_STAGES flops and
//   produces a one-clock pulse on the selected edge.
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   t0cki       : raw external clock pin
//   t0se        : 0 = rising edge, 1 = falling edge
//   edge_pulse  : one-clock pulse, valid the clock after the edge reaches
//                 the last synchronizer stage
module t0cki_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic t0cki,
    input  logic t0se,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= t0cki;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= synced;
        end
    end

    always_comb begin
        edge_pulse = 1'b0;
        if (t0se) begin
            edge_pulse = ~synced & prev_q;
        end else begin
            edge_pulse = synced & ~prev_q;
        end
    end

endmodule

// File: rtl/timer0_peripheral.sv
// timer0_peripheral
//   Timer0 responder on the core's external peripheral bus. Decodes TMR0
//   (0x001/0x101) and OPTION_REG (0x081/0x181), counts instruction cycles or
//   synchronized T0CKI edges through an optional prescaler, and pulses
//   t0if_set for one clock when TMR0 wraps from 0xFF to 0x00.
// Ports:
//   clk, rst                      : system clock, async active-high reset
//   extern_peripherals_addr       : 9-bit register-file address
//   extern_peripherals_data_in    : write data
//   extern_peripherals_wr_en      : one-clock write strobe
//   extern_peripherals_data_out   : combinational read data, 0x00 if unselected
//   periph_sel                    : combinational address hit
//   instr_cycle_tick              : one pulse per instruction cycle
//   t0cki                         : asynchronous external clock pin
//   t0if_set                      : registered one-clock overflow pulse
module timer0_peripheral
    import timer0_peripheral_pkg::*;
#(
    parameter int unsigned PRESCALER_W = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] extern_peripherals_addr,
    input  logic [7:0] extern_peripherals_data_in,
    input  logic       extern_peripherals_wr_en,
    output logic [7:0] extern_peripherals_data_out,
    output logic       periph_sel,
    input  logic       instr_cycle_tick,
    input  logic       t0cki,
    output logic       t0if_set
);

    localparam logic [PRESCALER_W-1:0] PRESC_ONE = 1;

    logic [7:0]             tmr0_q;
    logic [7:0]             option_q;
    logic [PRESCALER_W-1:0] presc_q;
    logic [1:0]             inhibit_q;
    logic                   t0if_q;

    reg_sel_e               reg_sel;
    logic                   tmr0_wr;
    logic                   option_wr;
    logic                   ext_edge;
    logic                   src_tick;
    logic                   inhibited;
    logic                   count_en;
    logic [PRESCALER_W-1:0] ps_mask;
    logic                   ps_full;
    logic                   inc;

    // ---------------------------------------------------------------- decode
    always_comb begin
        reg_sel = decode_reg(extern_peripherals_addr);
    end

    assign periph_sel = (reg_sel != REG_NONE);
    assign tmr0_wr    = extern_peripherals_wr_en && (reg_sel == REG_TMR0);
    assign option_wr  = extern_peripherals_wr_en && (reg_sel == REG_OPTION);

    always_comb begin
        extern_peripherals_data_out = '0;
        case (reg_sel)
            REG_TMR0:   extern_peripherals_data_out = tmr0_q;
            REG_OPTION: extern_peripherals_data_out = option_q;
            default:    extern_peripherals_data_out = '0;
        endcase
    end

    // ---------------------------------------------------------- tick source
    t0cki_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_t0cki_edge_sync (
        .clk        (clk),
        .rst        (rst),
        .t0cki      (t0cki),
        .t0se       (option_q[OPT_T0SE]),
        .edge_pulse (ext_edge)
    );

    assign src_tick  = option_q[OPT_T0CS] ? ext_edge : instr_cycle_tick;
    assign inhibited = (inhibit_q != 2'd0);
    assign count_en  = src_tick && !inhibited;

    // Prescaler fires when its low PS+1 bits are all ones, i.e. every
    // 2^(PS+1) source ticks, without ever resetting the counter itself.
    always_comb begin
        ps_mask = '0;
        for (int unsigned i = 0; i < PRESCALER_W; i++) begin
            ps_mask[i] = (i <= 32'(option_q[2:0]));
        end
    end

    assign ps_full = ((presc_q & ps_mask) == ps_mask);
    assign inc     = count_en && (option_q[OPT_PSA] || ps_full);

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr0_q    <= '0;
            option_q  <= OPTION_RST;
            presc_q   <= '0;
            inhibit_q <= '0;
            t0if_q    <= 1'b0;
        end else begin
            if (option_wr) begin
                option_q <= extern_peripherals_data_in;
            end

            if (tmr0_wr || option_wr) begin
                presc_q <= '0;
            end else if (count_en && !option_q[OPT_PSA]) begin
                presc_q <= presc_q + PRESC_ONE;
            end

            if (tmr0_wr) begin
                inhibit_q <= INHIBIT_LOAD;
            end else if (instr_cycle_tick && inhibited) begin
                inhibit_q <= inhibit_q - 2'd1;
            end

            // A TMR0 write overrides a coincident increment and its overflow.
            if (tmr0_wr) begin
                tmr0_q <= extern_peripherals_data_in;
            end else if (inc) begin
                tmr0_q <= tmr0_q + 8'd1;
            end

            t0if_q <= inc && !tmr0_wr && (tmr0_q == 8'hFF);
        end
    end

    assign t0if_set = t0if_q;

endmodule

// File: tb/tb_timer0_peripheral.sv
// tb_timer0_peripheral
//   Directed, self-checking bench for timer0_peripheral: a vector table for
//   decode/read/write behaviour plus hand-written multi-cycle sequences for
//   counting, prescaling, inhibit, external edges, overlaps and reset.
module tb_timer0_peripheral;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] addr = '0;
    logic [7:0] data_in = '0;
    logic       wr_en = 1'b0;
    logic [7:0] data_out;
    logic       periph_sel;
    logic       instr_cycle_tick = 1'b0;
    logic       t0cki = 1'b0;
    logic       t0if_set;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulse_cnt = 0;

    timer0_peripheral #(
        .PRESCALER_W(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .extern_peripherals_addr     (addr),
        .extern_peripherals_data_in  (data_in),
        .extern_peripherals_wr_en    (wr_en),
        .extern_peripherals_data_out (data_out),
        .periph_sel                  (periph_sel),
        .instr_cycle_tick            (instr_cycle_tick),
        .t0cki                       (t0cki),
        .t0if_set                    (t0if_set)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (t0if_set) pulse_cnt++;
    end

    typedef struct {
        logic [8:0] addr;
        logic [7:0] data;
        logic       wr;
        logic [7:0] exp_out;
        logic       exp_sel;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [8:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk(name, data_out, exp);
    endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; data_in = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        instr_cycle_tick = 1'b1;
        @(negedge clk);
        instr_cycle_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    vec_t vecs[15];
    int   base;

    initial begin
        vecs[0]  = '{9'h001, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[1]  = '{9'h081, 8'h00, 1'b0, 8'hFF, 1'b1};
        vecs[2]  = '{9'h101, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[3]  = '{9'h181, 8'h00, 1'b0, 8'hFF, 1'b1};
        vecs[4]  = '{9'h005, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{9'h000, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{9'h005, 8'h33, 1'b1, 8'h00, 1'b0};
        vecs[7]  = '{9'h001, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[8]  = '{9'h081, 8'h00, 1'b0, 8'hFF, 1'b1};
        vecs[9]  = '{9'h181, 8'h3C, 1'b1, 8'hFF, 1'b1};
        vecs[10] = '{9'h081, 8'h00, 1'b0, 8'h3C, 1'b1};
        vecs[11] = '{9'h001, 8'h42, 1'b1, 8'h00, 1'b1};
        vecs[12] = '{9'h101, 8'h00, 1'b0, 8'h42, 1'b1};
        vecs[13] = '{9'h0C1, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[14] = '{9'h1FF, 8'h00, 1'b0, 8'h00, 1'b0};

        // ---- reset
        repeat (2) @(negedge clk);
        chk("rst_t0if", {7'b0, t0if_set}, 8'h00);
        rst = 1'b0;

        // ---- table: decode, reads, writes, unmapped write
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            addr = vecs[i].addr; data_in = vecs[i].data; wr_en = vecs[i].wr;
            #1;
            chk($sformatf("vec%0d_data", i), data_out, vecs[i].exp_out);
            chk($sformatf("vec%0d_sel", i), {7'b0, periph_sel}, {7'b0, vecs[i].exp_sel});
        end
        @(negedge clk);
        wr_en = 1'b0;

        // ---- internal clock, no prescaler, overflow
        wr(9'h081, 8'h08);
        wr(9'h001, 8'hFD);
        ticks(2);
        rd("inhibit_hold", 9'h001, 8'hFD);
        ticks(2);
        rd("count_ff", 9'h001, 8'hFF);
        chk("no_early_t0if", {7'b0, t0if_set}, 8'h00);
        base = pulse_cnt;
        @(negedge clk);
        instr_cycle_tick = 1'b1;
        @(negedge clk);
        instr_cycle_tick = 1'b0;
        rd("wrap_00", 9'h001, 8'h00);
        chk("t0if_high", {7'b0, t0if_set}, 8'h01);
        @(negedge clk);
        chk("t0if_low", {7'b0, t0if_set}, 8'h00);
        repeat (4) @(negedge clk);
        chk("t0if_once", 8'(pulse_cnt - base), 8'h01);

        // ---- prescaler 1:4
        wr(9'h081, 8'h01);
        wr(9'h001, 8'h00);
        ticks(2);
        ticks(3);
        rd("ps_3ticks", 9'h001, 8'h00);
        tick();
        rd("ps_4ticks", 9'h001, 8'h01);
        ticks(4);
        rd("ps_8ticks", 9'h001, 8'h02);
        ticks(2);
        wr(9'h001, 8'h10);
        ticks(2);
        ticks(3);
        rd("ps_clr_3", 9'h001, 8'h10);
        tick();
        rd("ps_clr_4", 9'h001, 8'h11);

        // ---- external T0CKI, falling edge, no prescaler
        wr(9'h081, 8'h38);
        wr(9'h001, 8'h00);
        ticks(2);
        rd("ext_start", 9'h001, 8'h00);
        for (int p = 1; p <= 5; p++) begin
            @(negedge clk);
            t0cki = 1'b1;
            repeat (4) @(negedge clk);
            rd($sformatf("ext_rise%0d", p), 9'h001, 8'(p - 1));
            t0cki = 1'b0;
            repeat (2) @(negedge clk);
            rd($sformatf("ext_fall%0d_2clk", p), 9'h001, 8'(p - 1));
            @(negedge clk);
            rd($sformatf("ext_fall%0d_3clk", p), 9'h001, 8'(p));
        end

        // ---- mirrors and write/increment overlaps
        wr(9'h181, 8'h08);
        rd("opt_mirror_081", 9'h081, 8'h08);
        rd("opt_mirror_181", 9'h181, 8'h08);
        @(negedge clk);
        addr = 9'h101; data_in = 8'hA5; wr_en = 1'b1; instr_cycle_tick = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; instr_cycle_tick = 1'b0;
        rd("wr_beats_inc", 9'h001, 8'hA5);
        ticks(2);
        rd("inhibit_after_101", 9'h001, 8'hA5);
        @(negedge clk);
        addr = 9'h081; data_in = 8'h08; wr_en = 1'b1; instr_cycle_tick = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; instr_cycle_tick = 1'b0;
        rd("opt_wr_with_inc", 9'h001, 8'hA6);

        // ---- async reset with overflow pending
        wr(9'h001, 8'hFF);
        ticks(2);
        @(negedge clk);
        instr_cycle_tick = 1'b1;
        @(negedge clk);
        instr_cycle_tick = 1'b0;
        chk("pend_t0if", {7'b0, t0if_set}, 8'h01);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_drops_t0if", {7'b0, t0if_set}, 8'h00);
        rd("rst_tmr0", 9'h001, 8'h00);
        rd("rst_option", 9'h081, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        wr(9'h081, 8'h08);
        wr(9'h001, 8'h7F);
        ticks(2);
        rd("post_rst_hold", 9'h001, 8'h7F);
        tick();
        rd("post_rst_count", 9'h001, 8'h80);
        chk("post_rst_t0if", {7'b0, t0if_set}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
